// File: rtl/mcu_timer_if.sv
// Controller-to-timer register bus: control levels and reload data in, live count and expiry pulse out.
interface mcu_timer_if #(
  parameter int WIDTH = 16
);
  logic             timer_cs;
  logic             timer_wr;
  logic             timer_start;
  logic             timer_rd;
  logic [WIDTH-1:0] timer_datain;
  logic [WIDTH-1:0] timer_value;
  logic             timer_INT;

  modport master (
    output timer_cs, timer_wr, timer_start, timer_rd, timer_datain,
    input  timer_value, timer_INT
  );

  modport slave (
    input  timer_cs, timer_wr, timer_start, timer_rd, timer_datain,
    output timer_value, timer_INT
  );
endinterface

// File: rtl/mcu_timer.sv
// Auto-reloading down-counting interval timer with a one-cycle registered expiry pulse.
// Optional tick prescaler enabled by defining MCU_TIMER_PRESCALER_EN (divides ticks by PRESCALE).
module mcu_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  mcu_timer_if.slave  bus
);

  typedef enum logic {STOP, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ld_q, ld_d;
  logic             int_q, int_d;
  logic             run_en;
  logic             ld_ev;
  logic             tick;

  if (PRESCALE < 2 || PRESCALE > 255) begin : g_bad_prescale
    $error("mcu_timer: PRESCALE must be within 2..255");
  end

`ifdef MCU_TIMER_PRESCALER_EN
  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);
  logic [7:0] pre_q, pre_d;
`endif

  always_comb begin
    run_en   = bus.timer_cs & bus.timer_start;
    ld_d     = bus.timer_cs & bus.timer_wr;
    ld_ev    = ld_d & ~ld_q;
    state_d  = state_q;
    reload_d = reload_q;
    count_d  = count_q;
    int_d    = 1'b0;
`ifdef MCU_TIMER_PRESCALER_EN
    pre_d    = pre_q;
    tick     = (pre_q == PRE_LAST);
`else
    tick     = 1'b1;
`endif

    case (state_q)
      STOP:    if (run_en && reload_q != '0) state_d = RUN;
      RUN:     if (!run_en || reload_q == '0) state_d = STOP;
      default: state_d = STOP;
    endcase

    // A load wins over a tick; a stop wins over a tick and holds the count.
    if (ld_ev) begin
      reload_d = bus.timer_datain;
      count_d  = bus.timer_datain;
`ifdef MCU_TIMER_PRESCALER_EN
      pre_d    = '0;
`endif
    end else if (state_q == RUN) begin
      if (!run_en || reload_q == '0) begin
`ifdef MCU_TIMER_PRESCALER_EN
        pre_d = '0;
`endif
      end else begin
`ifdef MCU_TIMER_PRESCALER_EN
        pre_d = (pre_q == PRE_LAST) ? 8'd0 : pre_q + 8'd1;
`endif
        if (tick) begin
          if (count_q <= WIDTH'(1)) begin
            count_d = reload_q;
            int_d   = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STOP;
      reload_q <= '0;
      count_q  <= '0;
      ld_q     <= 1'b0;
      int_q    <= 1'b0;
`ifdef MCU_TIMER_PRESCALER_EN
      pre_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      ld_q     <= ld_d;
      int_q    <= int_d;
`ifdef MCU_TIMER_PRESCALER_EN
      pre_q    <= pre_d;
`endif
    end
  end

  assign bus.timer_value = (bus.timer_cs & bus.timer_rd) ? count_q : '0;
  assign bus.timer_INT   = int_q;

endmodule
